// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with grant wait states, byte enables and status words
module data_mem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned GNT_WAIT  = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  localparam int unsigned AW         = $clog2(DEPTH);
  localparam logic [3:0]  GNT_WAIT_C = 4'(GNT_WAIT);

  logic [31:0] mem_q [DEPTH];

  logic [3:0]  wcnt_q, wcnt_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] result_q, result_d;

  logic          in_range;
  logic [AW-1:0] idx;
  logic [31:0]   cur_word;
  logic [31:0]   merged_word;
  logic          wr_en;
  logic          unused_addr_lsb;

  // BASE_ADDR is aligned to the memory size, so range check and index reduce to bit slices
  assign in_range        = (data_addr_i[31:AW+2] == BASE_ADDR[31:AW+2]);
  assign idx             = data_addr_i[AW+1:2];
  assign unused_addr_lsb = ^data_addr_i[1:0];
  assign cur_word        = mem_q[idx];

  assign data_gnt_o = rst_ni && data_req_i && (wcnt_q == GNT_WAIT_C);
  assign wr_en      = data_gnt_o && data_we_i && in_range;

  always_comb begin
    merged_word = cur_word;
    for (int n = 0; n < 4; n++) begin
      if (data_be_i[n]) merged_word[8*n +: 8] = data_wdata_i[8*n +: 8];
    end
  end

  always_comb begin
    wcnt_d   = (data_req_i && !data_gnt_o) ? wcnt_q + 4'd1 : 4'd0;
    rvalid_d = data_gnt_o;
    err_d    = data_gnt_o && !in_range;
    rdata_d  = (data_gnt_o && !data_we_i && in_range) ? cur_word : 32'd0;
    done_d   = done_q | (wr_en && (idx == '0) && (merged_word != 32'd0));
    result_d = (wr_en && (idx == AW'(1))) ? merged_word : result_q;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wcnt_q   <= 4'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      rdata_q  <= 32'd0;
      result_q <= 32'd0;
    end else begin
      wcnt_q   <= wcnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      result_q <= result_d;
    end
  end

  // Storage deliberately has no reset so program memory survives a reset pulse
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[idx] <= merged_word;
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;
  assign done_o        = done_q;
  assign result_o      = result_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - randomized and directed bench with a behavioural memory model
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [2];
  logic        we [2];
  logic [31:0] addr [2];
  logic [3:0]  be [2];
  logic [31:0] wdata [2];
  logic        gnt [2];
  logic        rvalid [2];
  logic [31:0] rdata [2];
  logic        err [2];
  logic        done [2];
  logic [31:0] result [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .BASE_ADDR(32'h0000_0000), .GNT_WAIT(0)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[0]), .data_addr_i(addr[0]),
    .data_we_i(we[0]), .data_be_i(be[0]), .data_wdata_i(wdata[0]),
    .data_gnt_o(gnt[0]), .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]),
    .data_err_o(err[0]), .done_o(done[0]), .result_o(result[0]));

  data_mem_responder #(.DEPTH(64), .BASE_ADDR(32'h0001_0000), .GNT_WAIT(3)) u3 (
    .clk_i(clk), .rst_ni(rst_n), .data_req_i(req[1]), .data_addr_i(addr[1]),
    .data_we_i(we[1]), .data_be_i(be[1]), .data_wdata_i(wdata[1]),
    .data_gnt_o(gnt[1]), .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]),
    .data_err_o(err[1]), .done_o(done[1]), .result_o(result[1]));

  function automatic int dep_of(input int i);
    return (i == 0) ? 1024 : 64;
  endfunction

  function automatic logic [31:0] base_of(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'h0001_0000;
  endfunction

  function automatic int gw_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: expected register state after each edge
  logic [31:0] mm [2][1024];
  bit          mk [2][1024];
  int          held [2];
  bit          e_rvalid [2];
  bit          e_err [2];
  bit          e_rknown [2];
  bit          e_done [2];
  logic [31:0] e_rdata [2];
  logic [31:0] e_result [2];
  bit          armed = 1'b0;

  initial begin
    for (int i = 0; i < 2; i++) held[i] = 0;
    forever begin
      @(negedge clk);
      #3;
      for (int i = 0; i < 2; i++) begin : model
        bit          eg;
        bit          inr;
        bit          known;
        int          w;
        longint      la;
        logic [31:0] mg;
        eg = rst_n && req[i] && (held[i] == gw_of(i));
        if (armed) begin
          chk($sformatf("u%0d.gnt", i), {31'b0, gnt[i]}, {31'b0, eg});
          chk($sformatf("u%0d.rvalid", i), {31'b0, rvalid[i]}, {31'b0, e_rvalid[i]});
          if (e_rvalid[i]) begin
            chk($sformatf("u%0d.err", i), {31'b0, err[i]}, {31'b0, e_err[i]});
            if (e_rknown[i]) chk($sformatf("u%0d.rdata", i), rdata[i], e_rdata[i]);
          end
          chk($sformatf("u%0d.done", i), {31'b0, done[i]}, {31'b0, e_done[i]});
          chk($sformatf("u%0d.result", i), result[i], e_result[i]);
        end
        la  = longint'(addr[i]) - longint'(base_of(i));
        inr = (la >= 0) && (la < 4 * dep_of(i));
        w   = inr ? int'(la / 4) : 0;
        if (!rst_n) begin
          e_rvalid[i] = 0; e_err[i] = 0; e_rdata[i] = 0; e_rknown[i] = 1;
          e_done[i] = 0; e_result[i] = 0; held[i] = 0;
        end else begin
          e_rvalid[i] = eg;
          e_err[i]    = eg && !inr;
          e_rdata[i]  = 0;
          e_rknown[i] = 1;
          if (eg && inr && we[i]) begin
            mg = mm[i][w];
            for (int b = 0; b < 4; b++)
              if (be[i][b]) mg[8*b +: 8] = wdata[i][8*b +: 8];
            known = mk[i][w] || (be[i] == 4'hF);
            mm[i][w] = mg;
            mk[i][w] = known;
            if (w == 0 && known && mg != 0) e_done[i] = 1;
            if (w == 1) e_result[i] = mg;
          end else if (eg && inr) begin
            e_rdata[i]  = mm[i][w];
            e_rknown[i] = mk[i][w];
          end
          held[i] = (req[i] && !eg) ? held[i] + 1 : 0;
        end
      end
      if (!rst_n) armed = 1;
    end
  end

  task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, output logic [31:0] rd, output bit e, output int waits);
    bit got;
    got = 0; waits = -1; rd = 0; e = 0;
    req[i] = 1; we[i] = w; addr[i] = a; be[i] = b; wdata[i] = d;
    for (int k = 0; k < 40; k++) begin
      #4;
      if (gnt[i]) begin got = 1; waits = k; end
      @(negedge clk);
      if (got) break;
    end
    req[i] = 0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL u%0d.grant_timeout: got no grant, expected grant", i);
    end else begin
      #4;
      chk($sformatf("u%0d.rvalid_after_gnt", i), {31'b0, rvalid[i]}, 32'd1);
      rd = rdata[i];
      e  = err[i];
    end
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    bit          e;
    int          wt;
    logic [31:0] d;
    for (int i = 0; i < 2; i++) begin
      req[i] = 0; we[i] = 0; addr[i] = base_of(i); be[i] = 0; wdata[i] = 0;
    end
    rst_n = 0;
    repeat (2) @(negedge clk);
    req[0] = 1; addr[0] = 32'd20; be[0] = 4'hF;
    req[1] = 1;
    #4;
    chk("rst.gnt0", {31'b0, gnt[0]}, 32'd0);
    chk("rst.gnt1", {31'b0, gnt[1]}, 32'd0);
    chk("rst.rvalid", {31'b0, rvalid[0]}, 32'd0);
    chk("rst.err", {31'b0, err[0]}, 32'd0);
    chk("rst.rdata", rdata[0], 32'd0);
    chk("rst.done", {31'b0, done[0]}, 32'd0);
    chk("rst.result", result[0], 32'd0);
    @(negedge clk);
    rst_n = 1; req[0] = 0; req[1] = 0;
    #4;
    chk("rel.rvalid", {31'b0, rvalid[0]}, 32'd0);
    @(negedge clk);

    xact(0, 1, 32'd20, 4'hF, 32'hDEAD_BEEF, rd, e, wt);
    chk("w5.gnt_wait", wt, 32'd0);
    xact(0, 0, 32'd20, 4'h0, 32'd0, rd, e, wt);
    chk("r5.gnt_wait", wt, 32'd0);
    chk("r5.rdata", rd, 32'hDEAD_BEEF);
    chk("r5.err", {31'b0, e}, 32'd0);

    xact(0, 1, 32'd8, 4'hF, 32'h1122_3344, rd, e, wt);
    xact(0, 1, 32'd8, 4'b0101, 32'hAABB_CCDD, rd, e, wt);
    chk("be.write_rdata", rd, 32'd0);
    xact(0, 0, 32'd8, 4'h0, 32'd0, rd, e, wt);
    chk("be.rdata", rd, 32'h11BB_33DD);

    req[1] = 1; we[1] = 1; addr[1] = 32'h0001_000C; be[1] = 4'hF; wdata[1] = 32'h5555_AAAA;
    for (int k = 0; k < 2; k++) begin
      #4; chk("abort.gnt", {31'b0, gnt[1]}, 32'd0);
      @(negedge clk);
    end
    req[1] = 0;
    for (int k = 0; k < 3; k++) begin
      #4;
      chk("abort.gnt_after", {31'b0, gnt[1]}, 32'd0);
      chk("abort.rvalid", {31'b0, rvalid[1]}, 32'd0);
      @(negedge clk);
    end
    xact(1, 0, 32'h0001_0000 + 32'd4096, 4'h0, 32'd0, rd, e, wt);
    chk("gw3.oor_err", {31'b0, e}, 32'd1);
    chk("gw3.gnt_wait", wt, 32'd3);
    xact(1, 1, 32'h0001_000C, 4'hF, 32'h5555_AAAA, rd, e, wt);
    xact(1, 0, 32'h0001_000C, 4'h0, 32'd0, rd, e, wt);
    chk("gw3.rdata", rd, 32'h5555_AAAA);
    chk("gw3.read_wait", wt, 32'd3);

    xact(0, 1, 32'd0, 4'hF, 32'd0, rd, e, wt);
    xact(0, 0, 32'h0000_1000, 4'hF, 32'd0, rd, e, wt);
    chk("oor.rd_err", {31'b0, e}, 32'd1);
    chk("oor.rd_rdata", rd, 32'd0);
    xact(0, 1, 32'h0000_1000, 4'hF, 32'h1234_5678, rd, e, wt);
    chk("oor.wr_err", {31'b0, e}, 32'd1);
    chk("oor.done", {31'b0, done[0]}, 32'd0);
    chk("oor.result", result[0], 32'd0);
    xact(0, 0, 32'd0, 4'hF, 32'd0, rd, e, wt);
    chk("oor.word0", rd, 32'd0);

    xact(0, 1, 32'd4, 4'hF, 32'd55, rd, e, wt);
    chk("cmp.result", result[0], 32'd55);
    chk("cmp.done_pre", {31'b0, done[0]}, 32'd0);
    xact(0, 1, 32'd0, 4'hF, 32'd1, rd, e, wt);
    chk("cmp.done", {31'b0, done[0]}, 32'd1);
    xact(0, 1, 32'd0, 4'hF, 32'd0, rd, e, wt);
    chk("cmp.done_sticky", {31'b0, done[0]}, 32'd1);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #4;
    chk("cmp.done_rst", {31'b0, done[0]}, 32'd0);
    chk("cmp.result_rst", result[0], 32'd0);
    @(negedge clk);
    xact(0, 0, 32'd20, 4'hF, 32'd0, rd, e, wt);
    chk("keep.word5", rd, 32'hDEAD_BEEF);

    for (int j = 0; j <= 16; j++) begin
      if (j < 8) begin
        req[0] = 1; we[0] = 1; addr[0] = 32'(4 * (8 + j)); be[0] = 4'hF; wdata[0] = 32'hC0DE_0000 + 32'(j);
      end else if (j < 16) begin
        req[0] = 1; we[0] = 0; addr[0] = 32'(4 * j); be[0] = 4'h0;
      end else begin
        req[0] = 0;
      end
      #4;
      if (j < 16) chk("b2b.gnt", {31'b0, gnt[0]}, 32'd1);
      if (j > 0) chk("b2b.rvalid", {31'b0, rvalid[0]}, 32'd1);
      if (j > 8) chk("b2b.rdata", rdata[0], 32'hC0DE_0000 + 32'(j - 9));
      @(negedge clk);
    end

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) begin
        d = $urandom;
        xact(i, 1, base_of(i) + 32'(4 * w), 4'hF, d, rd, e, wt);
      end

    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          int w;
          req[i]   = ($urandom_range(0, 4) != 0);
          we[i]    = 1'($urandom_range(0, 1));
          be[i]    = 4'($urandom);
          wdata[i] = $urandom;
          w        = $urandom_range(0, 15);
          if ($urandom_range(0, 7) == 0)
            addr[i] = base_of(i) + 32'(4 * dep_of(i)) + 32'(4 * w);
          else if (i == 1 && $urandom_range(0, 15) == 0)
            addr[i] = base_of(i) - 32'(4 * (w + 1));
          else
            addr[i] = base_of(i) + 32'(4 * w);
          addr[i][1:0] = 2'($urandom_range(0, 3));
        end
      end
      @(negedge clk);
    end
    req[0] = 0; req[1] = 0;
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
